// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported memory between fetch and
// load/store; data wins arbitration until a bounded streak lets fetch in.
module memory_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_address,
   output logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_data,
   input  logic                  d_req,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [2:0]            d_length,
   output logic                  d_ready,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_input_data,
   output logic                  mem_write,
   output logic                  mem_read,
   output logic [2:0]            mem_op_length,
   input  logic                  mem_done,
   input  logic [DATA_WIDTH-1:0] mem_output_data,
   output logic [1:0]            grant,
   output logic                  protocol_error
);

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] FETCH = 2'b01;
   localparam logic [1:0] DATA  = 2'b10;
   localparam logic [1:0] RESP  = 2'b11;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [SW-1:0] streak;
   logic          resp_data;
   logic          rd_q;
   logic          wr_q;
   logic          busy;
   logic          take_data;
   logic          take_fetch;

   assign busy       = (state == FETCH) || (state == DATA);
   assign take_data  = d_req && !(if_req && streak == STREAK_MAX);
   assign take_fetch = if_req && !take_data;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (take_data)
               state_nxt = DATA;
            else if (take_fetch)
               state_nxt = FETCH;
         end
         FETCH, DATA: begin
            if (mem_done)
               state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_* are latched at grant so requester inputs may change afterwards
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state          <= IDLE;
         streak         <= '0;
         resp_data      <= 1'b0;
         rd_q           <= 1'b0;
         wr_q           <= 1'b0;
         mem_address    <= '0;
         mem_input_data <= '0;
         mem_op_length  <= '0;
         if_data        <= '0;
         d_rdata        <= '0;
         protocol_error <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && take_data) begin
            if (streak != STREAK_MAX)
               streak <= streak + SW'(1);
            resp_data      <= 1'b1;
            rd_q           <= !d_write;
            wr_q           <= d_write;
            mem_address    <= d_address;
            mem_input_data <= d_write ? d_wdata : '0;
            mem_op_length  <= d_length;
         end else if (state == IDLE && take_fetch) begin
            streak         <= '0;
            resp_data      <= 1'b0;
            rd_q           <= 1'b1;
            wr_q           <= 1'b0;
            mem_address    <= if_address;
            mem_input_data <= '0;
            mem_op_length  <= 3'b010;
         end
         if (busy && mem_done) begin
            if (state == FETCH)
               if_data <= mem_output_data;
            else if (!wr_q)
               d_rdata <= mem_output_data;
         end
         if (mem_done && !busy)
            protocol_error <= 1'b1;
      end
   end

   assign mem_req   = busy;
   assign mem_read  = rd_q & busy;
   assign mem_write = wr_q & busy;
   assign grant     = busy ? state : 2'b00;
   assign if_ready  = (state == RESP) && !resp_data;
   assign d_ready   = (state == RESP) && resp_data;

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Sequencer that shares one single-ported memory between the instruction-fetch path and the load/store path of the core. It accepts one request per requester, serialises them onto the memory port with a request/done handshake, and returns read data with a one-cycle ready pulse. Data accesses have priority, and a streak counter guarantees that fetch is not starved. It sits between the PC/fetch logic and the load/store decode signals on one side, and the shared memory on the other.

## Interface
- ADDR_WIDTH, 32, byte-address width on all address ports
- DATA_WIDTH, 32, data width on all data ports
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (≥1)

- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held high until if_ready
- if_address  in  ADDR_WIDTH  fetch byte address
- if_ready  out  1  one-cycle pulse: fetch complete, if_data valid
- if_data  out  DATA_WIDTH  fetched instruction, held until next fetch completion
- d_req  in  1  load/store request; held high until d_ready
- d_write  in  1  1 = store, 0 = load
- d_address  in  ADDR_WIDTH  data byte address
- d_wdata  in  DATA_WIDTH  store data
- d_length  in  3  access length code, passed to mem_op_length
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_WIDTH  load data, held until next data completion
- mem_req  out  1  memory transaction active
- mem_address  out  ADDR_WIDTH  registered address
- mem_input_data  out  DATA_WIDTH  registered store data (0 for fetch/load)
- mem_write  out  1  registered write strobe, valid while mem_req
- mem_read  out  1  registered read strobe, valid while mem_req
- mem_op_length  out  3  registered length; 3'b010 (word) for fetch
- mem_done  in  1  memory completed current transaction; mem_output_data valid
- mem_output_data  in  DATA_WIDTH  read data
- grant  out  2  01 = fetch owns port, 10 = data owns port, 00 = none
- protocol_error  out  1  sticky: mem_done seen with no transaction; cleared by reset only

## Operation
- States: IDLE, FETCH, DATA, RESP.
- IDLE arbitration, evaluated every cycle:
  - If d_req && !(if_req && streak == MAX_DATA_STREAK): grant data, go to DATA, streak = min(streak+1, MAX).
  - Else if if_req: grant fetch, go to FETCH, streak = 0.
  - Else: stay in IDLE.
- On grant, latch the address, write data, write/read and length into the mem_* registers.
  - Fetch: mem_read=1, mem_write=0, mem_op_length=3'b010, mem_input_data=0.
  - Load: mem_read=1, mem_write=0, mem_input_data=0.
  - Store: mem_write=1, mem_read=0.
  - Later requester input changes do not affect mem_*.
- FETCH/DATA: mem_req=1 and mem_* stable. Wait indefinitely for mem_done. On mem_done:
  - Capture mem_output_data into if_data (FETCH) or d_rdata (DATA load). For a store, d_rdata is unchanged.
  - Go to RESP.
- RESP: exactly one cycle.
  - Pulse if_ready or d_ready for the owner only.
  - mem_req=0, mem_read=0, mem_write=0, grant=00.
  - Next state is IDLE. Requests are not sampled in RESP, so a requester may drop req at this edge or keep it high to issue a back-to-back request.
- mem_done in IDLE or RESP: ignored for data, and sets protocol_error.
- Streak width: $clog2(MAX_DATA_STREAK+1). Saturates and never wraps.

## Timing
- Reset (reset_n=0 at a rising edge): state=IDLE, streak=0, and every output is 0, including if_data, d_rdata and protocol_error.
- Reset mid-transaction: mem_req drops at that edge and no ready pulse is generated. Any pending mem_done after reset is flagged only if it arrives while not in FETCH/DATA.
- Latency, zero-wait memory (mem_done high during the first mem_req cycle):
  - req sampled at edge N.
  - mem_req high in cycle N+1.
  - ready high in cycle N+2.
  - IDLE in cycle N+3.
  - Throughput is 1 access per 3 cycles. Each additional memory wait cycle adds 1.
- grant equals the state encoding: 01 in FETCH, 10 in DATA, 00 otherwise.
- Simultaneous if_req and d_req in IDLE: data wins unless streak == MAX_DATA_STREAK.
- ready outputs are never high in the same cycle as mem_req.

## Test plan
- Reset with if_req=d_req=1 and reset_n=0 for 2 cycles -> all outputs 0 and no mem_req; after release, first grant is data (streak 0).
- Single fetch: if_address=0x10, mem_done in the first cycle, mem_output_data=0x00500093 -> mem_address=0x10, mem_op_length=3'b010, if_ready pulses in cycle N+2, if_data=0x00500093.
- Store with 3 wait cycles: d_write=1, d_address=0x104, d_wdata=0xDEADBEEF, d_length=3'b010 -> mem_* stable for 4 cycles, d_ready pulses once, d_rdata unchanged.
- Starvation with MAX=4: if_req and d_req held high continuously -> grant sequence data ×4, fetch, data ×4, fetch.
- Back-to-back: d_req held high across the d_ready pulse with the address changed to 0x200 -> second transaction uses 0x200, and a new grant occurs in the cycle after RESP.
- Spurious mem_done in IDLE -> protocol_error=1 and stays 1 through subsequent transactions until reset_n=0.
